imu_burst_reader: RTL and testbench

Reads one fused-filter sample set from the SPI inertial measurement unit (MPU-6000 register map) on a fixed sample period. Reduces the raw 16-bit accelerometer-X, accelerometer-Z and gyro-Y words to 10-bit signed values. Presents them with a `data_ready` strobe. It is the producer side of the angle filter's `DataReady`/`Accel1`/`Accel2`/`Gyro` interface. That filter latches on the rising edge of `data_ready`, so data is always stable before the strobe rises.

---
 rtl/imu_pkg.sv | 34 +++
 rtl/spi_byte_shifter.sv | 73 +++++++
 rtl/imu_burst_reader.sv | 166 ++++++++++++++++
 tb/tb_imu_burst_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imu_pkg.sv
// imu_pkg: shared constants and types for the IMU burst reader.
//   - MPU-6000 register-map constants (burst start address, read bit, burst length)
//   - byte offsets of the three words the angle filter uses
//   - FSM state encoding, raw capture struct, output width and truncation helper
package imu_pkg;

  localparam logic [7:0] START_ADDR_DEF = 8'h3B;  // ACCEL_XOUT_H
  localparam logic [7:0] READ_BIT       = 8'h80;
  localparam int         BURST_LEN      = 14;

  // Big-endian word positions inside the burst
  localparam int OFS_AX = 0;
  localparam int OFS_AZ = 4;
  localparam int OFS_GY = 10;

  localparam int OUT_W    = 10;
  localparam int TRUNC_SH = 6;

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, READ, HOLD, LATCH, STROBE
  } state_t;

  typedef struct packed {
    logic [15:0] ax;
    logic [15:0] az;
    logic [15:0] gy;
  } raw_set_t;

  // Arithmetic shift then keep the low OUT_W bits: plain truncation, no rounding.
  function automatic logic signed [OUT_W-1:0] trunc_word(input logic [15:0] w);
    return OUT_W'($signed(w) >>> TRUNC_SH);
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: SPI mode-3 single-byte engine.
//   clk, rst_n : clock, async active-low reset
//   start      : begin a byte (may coincide with done for gap-free bursts)
//   tx         : byte to send MSB first
//   miso       : serial input, sampled on sclk rise
//   sclk, mosi : serial clock (idles high) and output (changes on sclk fall)
//   rx         : received byte, complete when done is high
//   done       : high in the last clk cycle of the byte's final sclk high half
// A byte lasts exactly 16*CLK_DIV clk cycles: 8 x (low half, high half).
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx,
  output logic       done
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    txsh;
  logic          half_end;

  assign half_end = (div_cnt == DIV_LAST);
  assign done     = active & sclk & half_end & (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      txsh    <= '0;
      rx      <= '0;
      sclk    <= 1'b1;
      mosi    <= 1'b1;
    end else if (start) begin
      // Starting a byte is itself the first falling edge.
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= tx[7];
      txsh    <= {tx[6:0], 1'b0};
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
          rx   <= {rx[6:0], miso};
        end else if (bit_cnt == 3'd7) begin
          active <= 1'b0;  // sclk parks high
        end else begin
          sclk    <= 1'b0;
          mosi    <= txsh[7];
          txsh    <= {txsh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/imu_burst_reader.sv
// imu_burst_reader: periodic burst read of the MPU-6000 over SPI mode 3.
// Reduces accel X / accel Z / gyro Y to 10-bit signed and publishes them
// with a one-cycle data_ready strobe, data stable one cycle before it rises.
//   clk, reset_n          : clock, async active-low reset
//   enable                : permits new transactions (a running one completes)
//   spi_miso              : IMU data in
//   spi_cs_n/sclk/mosi    : SPI master outputs
//   accel1, accel2, gyro  : reduced accel X, accel Z, gyro Y
//   data_ready            : new sample set strobe
//   busy                  : cs_n fall through publish
// Frame: SETUP (CLK_DIV) + 15 bytes (16*CLK_DIV each) + HOLD (CLK_DIV).
module imu_burst_reader
  import imu_pkg::*;
#(
  parameter int          CLK_DIV       = 4,
  parameter int          SAMPLE_PERIOD = 50000,
  parameter logic [7:0]  START_ADDR    = START_ADDR_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    spi_miso,
  output logic                    spi_cs_n,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  output logic signed [OUT_W-1:0] accel1,
  output logic signed [OUT_W-1:0] accel2,
  output logic signed [OUT_W-1:0] gyro,
  output logic                    data_ready,
  output logic                    busy
);

  localparam int TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(BURST_LEN - 1);
  localparam logic [7:0]    CMD_BYTE  = READ_BIT | {1'b0, START_ADDR[6:0]};

  state_t        state;
  logic [TW-1:0] timer;
  logic          tick;
  logic [DW-1:0] cnt;
  logic [3:0]    byte_cnt;
  raw_set_t      raw;

  logic          sh_start;
  logic [7:0]    sh_tx;
  logic [7:0]    sh_rx;
  logic          sh_done;

  // Free-running sample timer; runs regardless of FSM state so the period is exact.
  assign tick = (timer == TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer <= '0;
    else          timer <= tick ? '0 : timer + TW'(1);
  end

  // Byte starts are issued in the same cycle as the previous done so bytes
  // abut with no idle clk between them. MOSI idles at 1 during READ via 0xFF.
  always_comb begin
    sh_start = 1'b0;
    sh_tx    = 8'hFF;
    case (state)
      SETUP: if (cnt == DIV_LAST) begin
        sh_start = 1'b1;
        sh_tx    = CMD_BYTE;
      end
      CMD:     sh_start = sh_done;
      READ:    sh_start = sh_done && (byte_cnt != BYTE_LAST);
      default: ;
    endcase
  end

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk   (clk),
    .rst_n (reset_n),
    .start (sh_start),
    .tx    (sh_tx),
    .miso  (spi_miso),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi),
    .rx    (sh_rx),
    .done  (sh_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      spi_cs_n   <= 1'b1;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      cnt        <= '0;
      byte_cnt   <= '0;
      raw        <= '0;
      accel1     <= '0;
      accel2     <= '0;
      gyro       <= '0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks outside IDLE are simply lost.
          busy <= 1'b0;
          if (tick && enable) begin
            state    <= SETUP;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) state <= CMD;
          else                 cnt   <= cnt + DW'(1);
        end
        CMD: begin
          if (sh_done) begin
            state    <= READ;
            byte_cnt <= '0;
          end
        end
        READ: begin
          if (sh_done) begin
            case (byte_cnt)
              4'(OFS_AX):     raw.ax[15:8] <= sh_rx;
              4'(OFS_AX + 1): raw.ax[7:0]  <= sh_rx;
              4'(OFS_AZ):     raw.az[15:8] <= sh_rx;
              4'(OFS_AZ + 1): raw.az[7:0]  <= sh_rx;
              4'(OFS_GY):     raw.gy[15:8] <= sh_rx;
              4'(OFS_GY + 1): raw.gy[7:0]  <= sh_rx;
              default: ;
            endcase
            if (byte_cnt == BYTE_LAST) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (cnt == DIV_LAST) begin
            spi_cs_n <= 1'b1;
            state    <= LATCH;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        LATCH: begin
          accel1 <= trunc_word(raw.ax);
          accel2 <= trunc_word(raw.az);
          gyro   <= trunc_word(raw.gy);
          state  <= STROBE;
        end
        STROBE: begin
          // Strobe rises one edge after the outputs settle.
          data_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_burst_reader.sv
// Bench for imu_burst_reader: SPI IMU model, frame-timing monitor and an
// expected-sample queue drained whenever data_ready is seen.
module tb_imu_burst_reader;

  localparam int CD = 4;
  localparam int SP = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic spi_miso = 1'b0;
  logic spi_cs_n, spi_sclk, spi_mosi, data_ready, busy;
  logic signed [9:0] accel1, accel2, gyro;

  imu_burst_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .START_ADDR(8'h3B)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .spi_miso   (spi_miso),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .accel1     (accel1),
    .accel2     (accel2),
    .gyro       (gyro),
    .data_ready (data_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [9:0] a1;
    logic signed [9:0] a2;
    logic signed [9:0] g;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  logic [15:0] w_ax = 16'h0, w_az = 16'h0, w_gy = 16'h0;

  int cyc = 0;
  logic p_cs = 1'b1, p_sclk = 1'b1;
  logic in_frame = 1'b0;
  int sfalls = 0, len = 0, rise_cyc = -100, last_fall = -1;
  int cs_falls = 0, strobes = 0, f0 = 0, f1 = 0, ridx = 0;
  logic [7:0] cmd = 8'h0;
  logic [119:0] frame = '0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a1, input int a2, input int g);
    exp_t e;
    e.a1 = 10'(a1);
    e.a2 = 10'(a2);
    e.g  = 10'(g);
    q.push_back(e);
  endtask

  task automatic set_words(input logic [15:0] ax, input logic [15:0] az,
                           input logic [15:0] gy);
    w_ax = ax; w_az = az; w_gy = gy;
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (strobes < n && k < 4 * SP) begin
      @(negedge clk);
      k++;
    end
    if (strobes < n) begin
      tests++; fails++;
      $display("FAIL strobe_timeout: got %0d strobes expected %0d", strobes, n);
    end
  endtask

  task automatic wait_bits(input int n);
    int k = 0;
    while (!(!spi_cs_n && sfalls >= n) && k < 4 * SP) begin
      @(negedge clk);
      k++;
    end
    if (!(!spi_cs_n && sfalls >= n)) begin
      tests++; fails++;
      $display("FAIL bit_timeout: got %0d sclk falls expected %0d", sfalls, n);
    end
  endtask

  // IMU model + frame monitor + scoreboard, all sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      sfalls = 0; len = 0; in_frame = 1'b0; last_fall = -1;
    end else begin
      if (!enable) last_fall = -1;
      if (p_cs && !spi_cs_n) begin
        in_frame = 1'b1; cs_falls++; len = 0; sfalls = 0; ridx = 0; cmd = 8'h0;
        if (last_fall >= 0) chk("cs_period", cyc - last_fall, SP);
        last_fall = enable ? cyc : -1;
        frame = {8'h00, w_ax, 16'hA5A5, w_az, 32'hA5A5A5A5, w_gy, 16'hA5A5};
        chk("busy_at_cs_fall", 32'(busy), 1);
      end
      if (!spi_cs_n) len++;
      if (in_frame && p_sclk && !spi_sclk) begin
        if (sfalls < 120) spi_miso = frame[119 - sfalls];
        if (sfalls == 0) f0 = cyc;
        if (sfalls == 1) f1 = cyc;
        sfalls++;
      end
      if (in_frame && !p_sclk && spi_sclk && ridx < 8) begin
        cmd = {cmd[6:0], spi_mosi};
        ridx++;
      end
      if (in_frame && !p_cs && spi_cs_n) begin
        chk("cs_low_len", len, 968);
        chk("sclk_falls", sfalls, 120);
        chk("cmd_byte", 32'(cmd), 32'h0BB);
        chk("sclk_period", f1 - f0, 2 * CD);
        rise_cyc = cyc;
        in_frame = 1'b0;
      end
      if (data_ready) begin
        strobes++;
        chk("strobe_delay", cyc - rise_cyc, 2);
        chk("busy_at_strobe", 32'(busy), 1);
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("accel1", 32'(accel1), 32'(e.a1));
          chk("accel2", 32'(accel2), 32'(e.a2));
          chk("gyro", 32'(gyro), 32'(e.g));
        end
      end
    end
    p_cs = spi_cs_n;
    p_sclk = spi_sclk;
  end

  initial begin
    int fc;
    int n;
    set_words(16'h4000, 16'hC000, 16'hFFC0);
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(spi_cs_n), 1);
    chk("rst_sclk", 32'(spi_sclk), 1);
    chk("rst_mosi", 32'(spi_mosi), 1);
    chk("rst_accel1", 32'(accel1), 0);
    chk("rst_accel2", 32'(accel2), 0);
    chk("rst_gyro", 32'(gyro), 0);
    chk("rst_data_ready", 32'(data_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;

    // Idle with enable low: nothing may happen.
    repeat (10 * SP) @(negedge clk);
    chk("idle_cs_falls", cs_falls, 0);
    chk("idle_strobes", strobes, 0);
    chk("idle_cs_n", 32'(spi_cs_n), 1);
    chk("idle_sclk", 32'(spi_sclk), 1);
    chk("idle_accel1", 32'(accel1), 0);

    // Nominal burst.
    push_exp(256, -256, -1);
    enable = 1'b1;
    wait_strobes(1);

    // Truncation edges across two consecutive frames.
    set_words(16'h7FFF, 16'h8000, 16'h003F);
    push_exp(511, -512, 0);
    wait_strobes(2);
    set_words(16'hFFFF, 16'h7FC0, 16'h8040);
    push_exp(-1, 511, -511);
    wait_strobes(3);

    // Enable dropped during byte 5: frame completes, nothing further.
    set_words(16'h1234, 16'hFE00, 16'h0FC0);
    push_exp(72, -8, 63);
    wait_bits(48);
    enable = 1'b0;
    wait_strobes(4);
    fc = cs_falls;
    repeat (3 * SP) @(negedge clk);
    chk("no_cs_after_disable", cs_falls - fc, 0);

    // Reset during byte 7: immediate return to reset values, no strobe.
    set_words(16'h2000, 16'hE000, 16'h0040);
    enable = 1'b1;
    wait_bits(64);
    reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(spi_cs_n), 1);
    chk("midrst_sclk", 32'(spi_sclk), 1);
    chk("midrst_accel1", 32'(accel1), 0);
    chk("midrst_accel2", 32'(accel2), 0);
    chk("midrst_gyro", 32'(gyro), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("midrst_strobes", strobes, 4);
    reset_n = 1'b1;
    n = 0;
    while (spi_cs_n && n < 3 * SP) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("restart_delay", n, SP);
    push_exp(128, -128, 1);
    wait_strobes(5);
    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
